// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory between the
// CPU memory interface and the drawing-board DMA engine.
//
// Handshake (both requesters): req is a level held high until the matching
// one-cycle ready pulse; the command (we/addr/wdata) is captured in the cycle
// the arbiter grants, and later changes are ignored until the next grant. A
// requester must drop req, or present a new access, by the cycle after ready.
//
// Access sequence: IDLE (arbitrate) -> ISSUE (one memory cycle) ->
// WAIT (reads only, MEM_LAT cycles) -> DONE (ready pulse) -> IDLE.
// Every output is a flop; outputs that must be valid in the first cycle of a
// state are loaded from the next-state decode on the entering edge.

module mem_arbiter #(
  parameter int AW      = 10,
  parameter int MEM_LAT = 1   // legal range 1..3
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active low

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [31:0]   dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ready,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,

  output logic [1:0]    grant,      // 00 none, 01 CPU, 10 DMA
  output logic [1:0]    dbg_state   // FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT lasts MEM_LAT cycles: the counter starts at MEM_LAT-1 and the last
  // WAIT cycle is the one where it reads zero.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t        state_q;
  state_t        state_d;
  logic          take;        // IDLE with a request: grant this cycle
  logic          pick_dma;    // winner of this cycle's arbitration
  logic          sel_dma_q;   // port owning the current access
  logic          last_dma_q;  // port served most recently (1 = DMA)
  logic          lat_we_q;    // captured write enable of the current access
  logic [1:0]    cnt_q;       // WAIT down-counter
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [31:0]   win_wdata;
  logic          rd_sample;   // last WAIT cycle: mem_rdata is valid now

  // Only the word-address field of each byte address reaches the memory;
  // higher bits wrap and the byte-lane bits are meaningless for word access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                              dma_addr[31:AW+2], dma_addr[1:0]};

  // Command of the arbitration winner, captured on the granting edge.
  assign win_we    = pick_dma ? dma_we    : cpu_we;
  assign win_addr  = pick_dma ? dma_addr[AW+1:2] : cpu_addr[AW+1:2];
  assign win_wdata = pick_dma ? dma_wdata : cpu_wdata;

  assign rd_sample = (state_q == S_WAIT) && (cnt_q == 2'd0);
  assign dbg_state = state_q;

  // Next-state decode and round-robin arbitration.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    pick_dma = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          take = 1'b1;
          // DMA wins when it is alone, or on a tie when the CPU went last.
          pick_dma = dma_req && (!cpu_req || !last_dma_q);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = lat_we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, command capture and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_dma_q  <= 1'b0;
      last_dma_q <= 1'b1;   // DMA counts as last served: CPU wins the first tie
      lat_we_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q <= state_d;
      if (take) begin
        sel_dma_q <= pick_dma;
        lat_we_q  <= win_we;
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= CNT_INIT;
      end else if ((state_q == S_WAIT) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state_q == S_DONE) begin
        last_dma_q <= sel_dma_q;
      end
    end
  end

  // Memory-side outputs: enable only during ISSUE; address/data hold the
  // captured command for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= take;
      mem_we <= take && win_we;
      if (take) begin
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
      end
    end
  end

  // Grant is set on the granting edge, held through DONE, cleared in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= 2'b00;
    end else if (take) begin
      grant <= pick_dma ? 2'b10 : 2'b01;
    end else if (state_d == S_IDLE) begin
      grant <= 2'b00;
    end
  end

  // Requester-side outputs: read data captured at the end of the last WAIT
  // cycle into the owner's register only; ready pulses for the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
    end else begin
      if (rd_sample && !sel_dma_q) cpu_rdata <= mem_rdata;
      if (rd_sample &&  sel_dma_q) dma_rdata <= mem_rdata;
      cpu_ready <= (state_d == S_DONE) && !sel_dma_q;
      dma_ready <= (state_d == S_DONE) &&  sel_dma_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Two instances share the command
// inputs: inst a uses MEM_LAT=1, inst b uses MEM_LAT=3; each gets its own
// request lines and its own behavioural memory. Inputs change on the falling
// edge and outputs are checked on the falling edge; "cycle k" below counts
// from the cycle in which a request is first seen in IDLE (cycle 0).

module tb_mem_arbiter;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared command inputs ----------------
  logic        cpu_we = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;

  // ---------------- instance a (MEM_LAT = 1) ----------------
  logic          cpu_req_a = 1'b0, dma_req_a = 1'b0;
  logic [31:0]   cpu_rdata_a, dma_rdata_a, mem_wdata_a, mem_rdata_a;
  logic          cpu_ready_a, dma_ready_a, mem_en_a, mem_we_a;
  logic [AW-1:0] mem_addr_a;
  logic [1:0]    grant_a, dbg_state_a;

  mem_arbiter #(.AW(AW), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_a), .cpu_ready(cpu_ready_a),
    .dma_req(dma_req_a), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata_a), .dma_ready(dma_ready_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .grant(grant_a), .dbg_state(dbg_state_a)
  );

  // ---------------- instance b (MEM_LAT = 3) ----------------
  logic          cpu_req_b = 1'b0, dma_req_b = 1'b0;
  logic [31:0]   cpu_rdata_b, dma_rdata_b, mem_wdata_b, mem_rdata_b;
  logic          cpu_ready_b, dma_ready_b, mem_en_b, mem_we_b;
  logic [AW-1:0] mem_addr_b;
  logic [1:0]    grant_b, dbg_state_b;

  mem_arbiter #(.AW(AW), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_b), .cpu_ready(cpu_ready_b),
    .dma_req(dma_req_b), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata_b), .dma_ready(dma_ready_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .grant(grant_b), .dbg_state(dbg_state_b)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem_a [0:(1<<AW)-1];
  logic [31:0] rd_a = '0;
  assign mem_rdata_a = rd_a;

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      else          rd_a <= mem_a[mem_addr_a];
    end
  end

  logic [31:0] mem_b [0:(1<<AW)-1];
  logic [31:0] pb0 = '0, pb1 = '0, pb2 = '0;
  assign mem_rdata_b = pb2;

  always @(posedge clk) begin
    if (mem_en_b) begin
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      else          pb0 <= mem_b[mem_addr_b];
    end
    pb1 <= pb0;
    pb2 <= pb1;
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return cpu_ready_a;
      1:       return dma_ready_a;
      2:       return cpu_ready_b;
      default: return dma_ready_b;
    endcase
  endfunction

  // Bounded wait for a ready pulse; an expired bound is a failed check.
  task automatic wait_ready(input string tag, input int sel, input int max_cyc);
    int n = 0;
    while (!ready_of(sel) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(ready_of(sel)), 64'd1);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt, cpu_cnt, dma_cnt;

    // Reset state
    repeat (2) cyc();
    check("rst_grant",   64'(grant_a), 64'h0);
    check("rst_state",   64'(dbg_state_a), 64'h0);
    check("rst_mem_en",  64'({mem_en_a, mem_we_a, cpu_ready_a, dma_ready_a}), 64'h0);
    check("rst_addr",    64'({mem_addr_a, mem_wdata_a}), 64'h0);
    check("rst_rdata",   64'({cpu_rdata_a, dma_rdata_a}), 64'h0);
    rst_n = 1'b1;
    cyc();

    // CPU write 0xDEADBEEF to byte 0x10 (word 4)
    cpu_req_a = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
    cyc(); // cycle 1
    check("wr_c1_en_we", 64'({mem_en_a, mem_we_a}), 64'h3);
    check("wr_c1_addr",  64'(mem_addr_a), 64'd4);
    check("wr_c1_wdata", 64'(mem_wdata_a), 64'hDEAD_BEEF);
    check("wr_c1_grant", 64'(grant_a), 64'h1);
    check("wr_c1_rdy",   64'(cpu_ready_a), 64'h0);
    check("wr_c1_state", 64'(dbg_state_a), 64'h1);
    cyc(); // cycle 2
    check("wr_c2_rdy",   64'(cpu_ready_a), 64'h1);
    check("wr_c2_grant", 64'(grant_a), 64'h1);
    check("wr_c2_en",    64'(mem_en_a), 64'h0);
    cpu_req_a = 1'b0;
    cyc(); // cycle 3
    check("wr_c3_rdy",   64'(cpu_ready_a), 64'h0);
    check("wr_c3_grant", 64'(grant_a), 64'h0);

    // CPU read of the same word, MEM_LAT=1: ready in cycle 3
    cpu_req_a = 1'b1; cpu_we = 1'b0;
    cyc(); // cycle 1
    check("rd_c1_en_we", 64'({mem_en_a, mem_we_a}), 64'h2);
    check("rd_c1_addr",  64'(mem_addr_a), 64'd4);
    cyc(); // cycle 2
    check("rd_c2_rdy",   64'(cpu_ready_a), 64'h0);
    check("rd_c2_state", 64'(dbg_state_a), 64'h2);
    cyc(); // cycle 3
    check("rd_c3_rdy",   64'(cpu_ready_a), 64'h1);
    check("rd_c3_rdata", 64'(cpu_rdata_a), 64'hDEAD_BEEF);
    check("rd_c3_dma_rdata", 64'(dma_rdata_a), 64'h0);
    cpu_req_a = 1'b0;
    cyc();
    check("rd_c4_rdy",   64'(cpu_ready_a), 64'h0);

    // Request dropped and command changed during ISSUE: original access completes
    cpu_req_a = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h1234_5678;
    cyc(); // cycle 1 (ISSUE)
    check("drop_c1_addr",  64'(mem_addr_a), 64'd8);
    check("drop_c1_wdata", 64'(mem_wdata_a), 64'h1234_5678);
    cpu_req_a = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h0;
    cyc(); // cycle 2
    check("drop_c2_rdy",   64'(cpu_ready_a), 64'h1);
    cyc();
    cpu_req_a = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
    wait_ready("drop_rb_rdy", 0, 10);
    check("drop_rb_rdata", 64'(cpu_rdata_a), 64'h1234_5678);
    cpu_req_a = 1'b0;
    cyc();

    // Reset asserted during WAIT of a CPU read
    cpu_req_a = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    dma_we = 1'b0; dma_addr = 32'h0000_0010;
    cyc(); // cycle 1
    cyc(); // cycle 2 (WAIT)
    check("rstw_state_before", 64'(dbg_state_a), 64'h2);
    rst_n = 1'b0;
    dma_req_a = 1'b1;
    #1;
    check("rstw_grant", 64'(grant_a), 64'h0);
    check("rstw_state", 64'(dbg_state_a), 64'h0);
    check("rstw_ctl",   64'({mem_en_a, mem_we_a, cpu_ready_a, dma_ready_a}), 64'h0);
    check("rstw_rdata", 64'(cpu_rdata_a), 64'h0);
    check("rstw_addr",  64'(mem_addr_a), 64'h0);
    cyc(); // would have been DONE
    check("rstw_no_rdy", 64'(cpu_ready_a), 64'h0);
    rst_n = 1'b1;  // both requests pending: CPU must win the tie
    cyc(); // cycle 1
    check("rstw_tie_grant", 64'(grant_a), 64'h1);
    check("rstw_tie_en",    64'(mem_en_a), 64'h1);
    wait_ready("rstw_cpu_rdy", 0, 10);
    check("rstw_cpu_rdata", 64'(cpu_rdata_a), 64'hDEAD_BEEF);
    cpu_req_a = 1'b0;
    wait_ready("rstw_dma_rdy", 1, 10);
    check("rstw_dma_rdata", 64'(dma_rdata_a), 64'hDEAD_BEEF);
    dma_req_a = 1'b0;
    cyc();

    // Both requests held for 4 reads: strict alternation from reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    cpu_req_a = 1'b1; dma_req_a = 1'b1;
    done_cnt = 0; cpu_cnt = 0; dma_cnt = 0;
    for (int i = 0; i < 40 && done_cnt < 4; i++) begin
      cyc();
      if (cpu_ready_a || dma_ready_a) begin
        check("alt_grant", 64'(grant_a), 64'(exp_q.pop_front()));
        if (cpu_ready_a) begin
          cpu_cnt++;
          check("alt_cpu_rdata", 64'(cpu_rdata_a), 64'hDEAD_BEEF);
        end
        if (dma_ready_a) begin
          dma_cnt++;
          check("alt_dma_rdata", 64'(dma_rdata_a), 64'hDEAD_BEEF);
        end
        done_cnt++;
      end
    end
    cpu_req_a = 1'b0; dma_req_a = 1'b0;
    check("alt_done_cnt", 64'(done_cnt), 64'd4);
    check("alt_cpu_cnt",  64'(cpu_cnt),  64'd2);
    check("alt_dma_cnt",  64'(dma_cnt),  64'd2);
    cyc();
    cyc();

    // MEM_LAT=3: seed word 0 with a CPU write, then DMA read 0x1000 (wraps to 0)
    cpu_req_b = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'hCAFE_F00D;
    wait_ready("l3_wr_rdy", 2, 10);
    cpu_req_b = 1'b0;
    cyc();
    dma_req_b = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_1000;
    cyc(); // cycle 1
    check("l3_c1_en_we", 64'({mem_en_b, mem_we_b}), 64'h2);
    check("l3_c1_addr",  64'(mem_addr_b), 64'd0);
    check("l3_c1_grant", 64'(grant_b), 64'h2);
    cyc(); cyc(); cyc(); // cycles 2..4
    check("l3_c4_rdy",   64'(dma_ready_b), 64'h0);
    cyc(); // cycle 5
    check("l3_c5_rdy",   64'(dma_ready_b), 64'h1);
    check("l3_c5_rdata", 64'(dma_rdata_b), 64'hCAFE_F00D);
    check("l3_cpu_rdata_hold", 64'(cpu_rdata_b), 64'h0);
    dma_req_b = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
